// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states, owner ids and default wait count.
package sram_arbiter_pkg;

    localparam int REG_WIDTH         = 32;
    localparam int INST_ADDR_WIDTH   = 32;
    localparam int SRAM_WAIT_DEFAULT = 1;

    typedef enum logic [1:0] {
        SRAM_IDLE   = 2'd0,
        SRAM_ACCESS = 2'd1,
        SRAM_DONE   = 2'd2
    } sram_state_t;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates fetch and mem-stage requests onto one single-port asynchronous SRAM,
// sequencing the multi-cycle strobe timing and returning a one-cycle ack per access.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT,
    parameter int SRAM_AW     = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inst_req_i,
    input  logic [INST_ADDR_WIDTH-1:0] inst_addr_i,
    output logic [REG_WIDTH-1:0]       inst_rdata_o,
    output logic                       inst_ack_o,
    input  logic                       data_req_i,
    input  logic                       data_we_i,
    input  logic [REG_WIDTH-1:0]       data_addr_i,
    input  logic [3:0]                 data_sel_i,
    input  logic [REG_WIDTH-1:0]       data_wdata_i,
    output logic [REG_WIDTH-1:0]       data_rdata_o,
    output logic                       data_ack_o,
    input  logic                       flush_i,
    output logic                       pause_if_o,
    output logic                       pause_mem_o,
    output logic [SRAM_AW-1:0]         sram_addr_o,
    output logic [REG_WIDTH-1:0]       sram_wdata_o,
    output logic                       sram_wdata_oe_o,
    input  logic [REG_WIDTH-1:0]       sram_rdata_i,
    output logic                       sram_ce_n_o,
    output logic                       sram_oe_n_o,
    output logic                       sram_we_n_o,
    output logic [3:0]                 sram_be_n_o
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    sram_state_t      state;
    owner_t           owner;
    logic             we_q;
    logic             flushed;
    logic             inst_ack_q;
    logic [CNT_W-1:0] cnt;
    logic             grant_write;
    logic             unused_addr_bits;

    assign grant_write = data_req_i & data_we_i;

    // Only the word address reaches the SRAM; byte offset and high bits are dropped.
    assign unused_addr_bits = ^{inst_addr_i[INST_ADDR_WIDTH-1:SRAM_AW+2], inst_addr_i[1:0],
                                data_addr_i[REG_WIDTH-1:SRAM_AW+2], data_addr_i[1:0]};

    assign inst_ack_o  = inst_ack_q & ~flush_i;
    assign pause_if_o  = inst_req_i & ~inst_ack_o;
    assign pause_mem_o = data_req_i & ~data_ack_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= SRAM_IDLE;
            owner           <= OWNER_INST;
            we_q            <= 1'b0;
            flushed         <= 1'b0;
            cnt             <= '0;
            inst_ack_q      <= 1'b0;
            data_ack_o      <= 1'b0;
            inst_rdata_o    <= '0;
            data_rdata_o    <= '0;
            sram_addr_o     <= '0;
            sram_wdata_o    <= '0;
            sram_wdata_oe_o <= 1'b0;
            sram_ce_n_o     <= 1'b1;
            sram_oe_n_o     <= 1'b1;
            sram_we_n_o     <= 1'b1;
            sram_be_n_o     <= 4'hF;
        end else begin
            inst_ack_q <= 1'b0;
            data_ack_o <= 1'b0;
            case (state)
                SRAM_IDLE: begin
                    // Data wins a tie so a stalled mem stage never starves behind fetch.
                    if (data_req_i || inst_req_i) begin
                        owner           <= data_req_i ? OWNER_DATA : OWNER_INST;
                        we_q            <= grant_write;
                        sram_addr_o     <= data_req_i ? data_addr_i[SRAM_AW+1:2]
                                                      : inst_addr_i[SRAM_AW+1:2];
                        if (data_req_i) begin
                            sram_wdata_o <= data_wdata_i;
                        end
                        sram_wdata_oe_o <= grant_write;
                        sram_ce_n_o     <= 1'b0;
                        sram_oe_n_o     <= grant_write;
                        sram_we_n_o     <= ~grant_write;
                        sram_be_n_o     <= grant_write ? ~data_sel_i : 4'h0;
                        cnt             <= CNT_W'(WAIT_CYCLES);
                        flushed         <= 1'b0;
                        state           <= SRAM_ACCESS;
                    end
                end
                SRAM_ACCESS: begin
                    if (owner == OWNER_INST && flush_i) begin
                        flushed <= 1'b1;
                    end
                    if (cnt == '0) begin
                        sram_ce_n_o     <= 1'b1;
                        sram_oe_n_o     <= 1'b1;
                        sram_we_n_o     <= 1'b1;
                        sram_be_n_o     <= 4'hF;
                        sram_wdata_oe_o <= 1'b0;
                        if (owner == OWNER_DATA) begin
                            data_rdata_o <= sram_rdata_i;
                            data_ack_o   <= 1'b1;
                        end else begin
                            inst_rdata_o <= sram_rdata_i;
                            inst_ack_q   <= ~(flushed | flush_i);
                        end
                        state <= SRAM_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        // Release we_n one cycle early so data and address are held past it.
                        if (we_q && cnt == CNT_W'(1)) begin
                            sram_we_n_o <= 1'b1;
                        end
                    end
                end
                SRAM_DONE: begin
                    state <= SRAM_IDLE;
                end
                default: begin
                    state <= SRAM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares one single-port external SRAM between the instruction-fetch requester and the mem-stage data requester. The data requester is driven by mem's mem_addr_o, store_data_o, mem_write_en_o, mem_select_o and ram_en_o. The block sequences multi-cycle SRAM read and write timing, returns read data with a one-cycle ack, and raises pause signals to ctrl while a requester waits.

Parameters:
WAIT_CYCLES, 1, extra SRAM cycles per access; must be >= 1.
SRAM_AW, 20, SRAM word-address width; SRAM address = byte address[SRAM_AW+1:2].

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_req_i  in  1  fetch read request, held until ack
inst_addr_i  in  32  fetch byte address
inst_rdata_o  out  32  fetch read data, valid with ack
inst_ack_o  out  1  one-cycle fetch completion
data_req_i  in  1  mem-stage request (ram_en), held until ack
data_we_i  in  1  1 = write
data_addr_i  in  32  data byte address
data_sel_i  in  4  byte select, bit3 = bits[31:24] = byte offset 00
data_wdata_i  in  32  store data (lanes pre-replicated by mem)
data_rdata_o  out  32  load data, valid with ack
data_ack_o  out  1  one-cycle data completion
flush_i  in  1  ctrl flush; cancels fetch ack
pause_if_o  out  1  stall request to ctrl for fetch
pause_mem_o  out  1  stall request to ctrl for mem
sram_addr_o  out  SRAM_AW  word address
sram_wdata_o  out  32  write data
sram_wdata_oe_o  out  1  tristate enable for top-level bidirectional bus
sram_rdata_i  in  32  read data
sram_ce_n_o / sram_oe_n_o / sram_we_n_o  out  1 each  active-low strobes
sram_be_n_o  out  4  active-low byte enables

Behaviour:
- States: IDLE, ACCESS, DONE. Every SRAM output and ack is registered.
- Reset (synchronous): state IDLE; ce_n/oe_n/we_n = 1; be_n = 4'hF; addr, wdata, wdata_oe, both rdata regs, acks and owner = 0.
- IDLE grant rule:
  - data_req_i wins over inst_req_i; when both are asserted, data is granted and fetch waits.
  - On grant: latch owner, address, we, sel and wdata; load cnt = WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - ce_n = 0; be_n = ~sel for writes, 4'h0 for reads.
  - Read: oe_n = 0.
  - Write: wdata_oe = 1; we_n = 0 while cnt != 0 and 1 on the final cycle, giving data/address hold.
  - cnt decrements each cycle. At cnt == 0, latch sram_rdata_i into the owner's rdata reg and go to DONE.
  - ACCESS lasts WAIT_CYCLES+1 cycles.
- DONE:
  - Strobes deasserted; owner's ack = 1 for exactly one cycle.
  - Next state is always IDLE. This prevents re-issuing a still-held request in the ack cycle.
- Latency: request seen in IDLE at cycle T gives ack at cycle T+WAIT_CYCLES+2 (T+3 at default).
- Pause outputs (combinational):
  - pause_mem_o = data_req_i & ~data_ack_o.
  - pause_if_o = inst_req_i & ~inst_ack_o.
- rdata regs hold their value until the next completion of the same owner.
- flush_i:
  - During a fetch access (ACCESS or DONE owned by fetch), the SRAM cycle completes but inst_ack_o is suppressed.
  - A flush arriving in IDLE does not affect a new grant.
  - flush_i never affects a data access; a committed store always completes.
- data_sel_i == 0 on a write: the access is performed with be_n = 4'hF (no byte written), and ack is still issued.
- rst during ACCESS: strobes return to 1 at that edge and state goes to IDLE; no ack is issued.
- Request dropped mid-access: the access still completes and ack is still pulsed.

Decomposition:
- Shared define file additions: state encodings (SRAM_IDLE/ACCESS/DONE), OWNER_INST/OWNER_DATA, default SRAM wait count. Reuse existing `RegWidth / `InstAddrWidth.
- Single module; the wait counter is inline. No sub-module is needed.

Test Plan:
- Fetch read of addr 0x80000010, WAIT=1, sram_rdata=0xDEADBEEF -> sram_addr=0x00004; oe_n low 2 cycles; inst_ack at T+3 with inst_rdata=0xDEADBEEF; pause_if high T..T+2.
- Simultaneous inst_req and data_req (load 0x80000100) -> data served first (ack T+3), fetch granted T+4, inst_ack at T+7; pause_if held through T+6.
- Store byte 0x80000003, sel=0001, wdata=0x5A5A5A5A -> be_n=1110; we_n low 1 cycle then high 1 cycle; wdata_oe=1 through ACCESS; data_ack at T+3.
- flush_i pulsed during fetch ACCESS -> SRAM read completes, no inst_ack, state IDLE at T+4; a store under flush still gets data_ack.
- rst asserted in first ACCESS cycle of a write -> next cycle all strobes = 1, be_n=F, no ack, state IDLE.
- WAIT_CYCLES=3 load -> oe_n low 4 cycles; data_ack at T+5.
